p88_loader: RTL and testbench
=============================

// Module: p88_loader
// PURPOSE
// Streams a P88 program image from the HPS ioctl download channel into system memory.
// Decodes data records (CMD_DATA) and entry-vector records (CMD_VEC).
// Drives a request/acknowledge write port into DRAM and the boot-vector ROM.
// Holds the CPU/SlipStream in reset for the whole load, then releases it.
// Sits between hps_io and m_konix; replaces the fixed-delay loader inside m_konix.
// PARAMETERS
// ADDR_W      20     memory byte-address width; seg*16+off is truncated to this width
// LEN_W       16     data-record length field width (bytes; header always carries 2 bytes)
// VEC_ADDR_W  3      boot-vector ROM address width; 5 vector bytes must fit (>=3)
// CMD_DATA    8'hC8  data-record command byte
// CMD_VEC     8'hCA  entry-vector record command byte
// REL_CYCLES  4      clk_sys cycles cpu_reset stays high after download falls (>=1)
// PORTS
// clk_sys          in   1           system clock; all logic on posedge
// resetL           in   1           asynchronous active-low reset
// ioctl_download   in   1           high while a file transfer is in progress
// ioctl_wr         in   1           one-cycle strobe; ioctl_dout is valid
// ioctl_dout       in   8           download byte
// ioctl_wait       out  1           stall to hps_io; high while a memory write is outstanding
// cpu_reset        out  1           system reset request (ORed with the external reset)
// mem_addr         out  ADDR_W      write address (DRAM, or ROM using the low VEC_ADDR_W bits)
// mem_data         out  8           write data
// ram_req          out  1           DRAM write request; held until mem_ack
// rom_req          out  1           vector-ROM write request; held until mem_ack
// mem_ack          in   1           write accepted this cycle
// load_err         out  1           sticky error for the current download
// bytes_written    out  LEN_W+8     count of payload bytes written this download
// BEHAVIOUR
// Reset: all outputs 0, state IDLE, internal counters 0.
// - Download rise (edge-detected): cpu_reset=1, load_err=0, bytes_written=0, state CMD.
// - ioctl_wr is ignored outside a download.
// CMD: on ioctl_wr, byte==CMD_DATA -> DHDR, hdr_cnt=0; byte==CMD_VEC -> VHDR, hdr_cnt=0.
//   Any other byte -> ERR and load_err=1. ERR discards all bytes until download falls.
// DHDR: 8 bytes, little-endian: segL segH offL offH skip skip lenL lenH.
//   addr=(seg<<4)+off, mod 2^ADDR_W.
//   len==0 -> CMD with no write. Otherwise -> DATA.
// DATA: on ioctl_wr, latch the byte into mem_data, mem_addr=addr, ram_req=1, ioctl_wait=1 -> DWAIT.
// DWAIT: on mem_ack, drop ram_req and ioctl_wait the next cycle.
//   Also in that cycle: addr+=1 (wraps at 2^ADDR_W), len-=1, bytes_written+=1.
//   Then len==0 -> CMD, else -> DATA.
// VHDR: 4 bytes segL segH offL offH. After the 4th byte, ioctl_wait=1 -> VEC with vidx=0.
// VEC/VWAIT: write EA, offL, offH, segL, segH to ROM addresses 0..4.
//   Each write: rom_req=1, hold until mem_ack, one idle cycle between writes.
//   ioctl_wait drops in the cycle after the 5th ack; state -> CMD.
// Requests are single-cycle-ack tolerant. ram_req and rom_req are never high together.
//   mem_addr and mem_data are stable while a request is high.
// ioctl_wr arriving while ioctl_wait=1 is a protocol violation: load_err=1 and the byte is dropped.
// Download fall:
//   - Any state other than CMD or ERR (truncated record) -> load_err=1.
//   - An outstanding request still completes on mem_ack, then the machine enters IDLE.
//   - cpu_reset drops REL_CYCLES cycles after IDLE is entered.
//   - A new download rise during the release countdown restarts the load.
// resetL low mid-operation: immediate return to IDLE, cpu_reset=0, requests dropped.
// Latency: ioctl_wr to ram_req is 1 cycle. Each payload byte takes >=3 cycles when ack is immediate.
// TESTING
// Data record C8 00 10 04 00 xx xx 03 00 AA BB CC, immediate ack:
//   -> DRAM 0x10004=AA, 0x10005=BB, 0x10006=CC; bytes_written=3; load_err=0.
// Vector record CA 34 12 78 56:
//   -> ROM[0..4] = EA 78 56 34 12; ioctl_wait high throughout; cpu_reset low REL_CYCLES cycles after download ends.
// Address wrap: C8 FF FF 0F 00 ... len=2:
//   -> writes at 0xFFFFF then 0x00000.
// mem_ack delayed 5 cycles per write:
//   -> requests and address/data held stable; no byte lost; ioctl_wait covers each stall.
// Unknown command 0x55, or download dropped mid-DATA:
//   -> load_err=1; no further writes; cpu_reset still released.
// resetL asserted during DWAIT:
//   -> all outputs 0 asynchronously; the next download loads correctly.

Source files
------------

// File: rtl/p88_loader_if.sv
// Bundle between hps_io, the P88 loader and the memory write arbiter.
// No logic of its own: carries the download stream, the write port and status.
// Stall/ack semantics are defined by the loader (ioctl_wait, mem_ack).
interface p88_loader_if #(
   parameter int ADDR_W = 20,
   parameter int LEN_W  = 16
);
   logic                 ioctl_download;
   logic                 ioctl_wr;
   logic [7:0]           ioctl_dout;
   logic                 ioctl_wait;
   logic                 cpu_reset;
   logic [ADDR_W-1:0]    mem_addr;
   logic [7:0]           mem_data;
   logic                 ram_req;
   logic                 rom_req;
   logic                 mem_ack;
   logic                 load_err;
   logic [LEN_W+7:0]     bytes_written;

   // Loader side
   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_dout, mem_ack,
      output ioctl_wait, cpu_reset, mem_addr, mem_data, ram_req, rom_req,
             load_err, bytes_written
   );

   // Environment side (hps_io + memory)
   modport master (
      output ioctl_download, ioctl_wr, ioctl_dout, mem_ack,
      input  ioctl_wait, cpu_reset, mem_addr, mem_data, ram_req, rom_req,
             load_err, bytes_written
   );
endinterface

// File: rtl/p88_loader.sv
// P88 image loader: parses C8 data / CA vector records into DRAM and boot-vector ROM writes.
// Latency: ioctl_wr to ram_req 1 cycle; >=3 cycles per payload byte with immediate ack.
// Backpressure: ioctl_wait held while a write is outstanding; requests held until mem_ack.
module p88_loader #(
   parameter int         ADDR_W     = 20,
   parameter int         LEN_W      = 16,
   parameter int         VEC_ADDR_W = 3,
   parameter logic [7:0] CMD_DATA   = 8'hC8,
   parameter logic [7:0] CMD_VEC    = 8'hCA,
   parameter int         REL_CYCLES = 4
) (
   input logic              clk_sys,
   input logic              resetL,
   p88_loader_if.slave      bus
);
   localparam int RC_W = (REL_CYCLES > 1) ? $clog2(REL_CYCLES) : 1;
   localparam int BW_W = LEN_W + 8;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_DHDR, S_DATA, S_DWAIT, S_VHDR, S_VEC, S_VWAIT, S_ERR
   } state_t;

   state_t                state_q;
   logic                  dl_q;
   logic [39:0]           hdr_q;      // segL segH offL offH lenL
   logic [2:0]            hdr_cnt_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [LEN_W-1:0]      len_q;
   logic [VEC_ADDR_W-1:0] vidx_q;
   logic [RC_W-1:0]       rel_q;
   logic                  wait_q;
   logic                  cpu_reset_q;
   logic [ADDR_W-1:0]     mem_addr_q;
   logic [7:0]            mem_data_q;
   logic                  ram_req_q;
   logic                  rom_req_q;
   logic                  load_err_q;
   logic [BW_W-1:0]       bw_q;

   logic                  dl_rise;
   logic                  wr_in;
   logic                  byte_ok;
   logic                  busy_wait;
   logic [ADDR_W-1:0]     rec_addr_d;
   logic [LEN_W-1:0]      rec_len_d;
   logic [7:0]            vec_byte_d;

   // Derived strobes, record address/length from the header, and vector byte select
   always_comb begin
      dl_rise    = bus.ioctl_download & ~dl_q;
      wr_in      = bus.ioctl_wr & bus.ioctl_download;
      byte_ok    = wr_in & ~wait_q;
      busy_wait  = (state_q == S_DWAIT) || (state_q == S_VWAIT);
      rec_addr_d = ADDR_W'({hdr_q[15:0], 4'b0000}) + ADDR_W'(hdr_q[31:16]);
      rec_len_d  = LEN_W'({bus.ioctl_dout, hdr_q[39:32]});
      vec_byte_d = 8'hEA;
      case (vidx_q)
         VEC_ADDR_W'(1): vec_byte_d = hdr_q[23:16];
         VEC_ADDR_W'(2): vec_byte_d = hdr_q[31:24];
         VEC_ADDR_W'(3): vec_byte_d = hdr_q[7:0];
         VEC_ADDR_W'(4): vec_byte_d = hdr_q[15:8];
         default:        vec_byte_d = 8'hEA;
      endcase
   end

   // Record parser, write-port sequencer and CPU reset release, all outputs registered
   always_ff @(posedge clk_sys or negedge resetL) begin
      if (!resetL) begin
         state_q     <= S_IDLE;
         dl_q        <= 1'b0;
         hdr_q       <= '0;
         hdr_cnt_q   <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         vidx_q      <= '0;
         rel_q       <= '0;
         wait_q      <= 1'b0;
         cpu_reset_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         ram_req_q   <= 1'b0;
         rom_req_q   <= 1'b0;
         load_err_q  <= 1'b0;
         bw_q        <= '0;
      end else begin
         dl_q <= bus.ioctl_download;
         // A byte pushed during a stall is dropped and flagged
         if (wr_in && wait_q)
            load_err_q <= 1'b1;
         // Download ended with a record half-parsed
         if (!bus.ioctl_download && state_q != S_IDLE && state_q != S_CMD && state_q != S_ERR)
            load_err_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               // A rise only restarts from IDLE, including during the release countdown
               if (dl_rise) begin
                  state_q     <= S_CMD;
                  cpu_reset_q <= 1'b1;
                  load_err_q  <= 1'b0;
                  bw_q        <= '0;
               end else if (cpu_reset_q) begin
                  if (rel_q == '0)
                     cpu_reset_q <= 1'b0;
                  else
                     rel_q <= rel_q - RC_W'(1);
               end
            end
            S_CMD: begin
               if (byte_ok) begin
                  hdr_cnt_q <= '0;
                  if (bus.ioctl_dout == CMD_DATA)
                     state_q <= S_DHDR;
                  else if (bus.ioctl_dout == CMD_VEC)
                     state_q <= S_VHDR;
                  else begin
                     state_q    <= S_ERR;
                     load_err_q <= 1'b1;
                  end
               end
            end
            S_DHDR, S_VHDR: begin
               if (byte_ok) begin
                  hdr_cnt_q <= hdr_cnt_q + 3'd1;
                  if (hdr_cnt_q < 3'd4)
                     hdr_q[{hdr_cnt_q[1:0], 3'b000} +: 8] <= bus.ioctl_dout;
                  if (hdr_cnt_q == 3'd6)
                     hdr_q[39:32] <= bus.ioctl_dout;
                  if (state_q == S_VHDR && hdr_cnt_q == 3'd3) begin
                     wait_q  <= 1'b1;
                     vidx_q  <= '0;
                     state_q <= S_VEC;
                  end
                  if (state_q == S_DHDR && hdr_cnt_q == 3'd7) begin
                     addr_q  <= rec_addr_d;
                     len_q   <= rec_len_d;
                     state_q <= (rec_len_d == '0) ? S_CMD : S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (byte_ok) begin
                  mem_addr_q <= addr_q;
                  mem_data_q <= bus.ioctl_dout;
                  ram_req_q  <= 1'b1;
                  wait_q     <= 1'b1;
                  state_q    <= S_DWAIT;
               end
            end
            S_DWAIT: begin
               if (bus.mem_ack) begin
                  ram_req_q <= 1'b0;
                  wait_q    <= 1'b0;
                  addr_q    <= addr_q + ADDR_W'(1);
                  len_q     <= len_q - LEN_W'(1);
                  bw_q      <= bw_q + BW_W'(1);
                  state_q   <= (len_q == LEN_W'(1)) ? S_CMD : S_DATA;
               end
            end
            S_VEC: begin
               // Not issued once the download has gone; the machine heads to IDLE instead
               if (bus.ioctl_download) begin
                  mem_addr_q <= ADDR_W'(vidx_q);
                  mem_data_q <= vec_byte_d;
                  rom_req_q  <= 1'b1;
                  state_q    <= S_VWAIT;
               end
            end
            S_VWAIT: begin
               if (bus.mem_ack) begin
                  rom_req_q <= 1'b0;
                  if (vidx_q == VEC_ADDR_W'(4)) begin
                     wait_q  <= 1'b0;
                     state_q <= S_CMD;
                  end else begin
                     vidx_q  <= vidx_q + VEC_ADDR_W'(1);
                     state_q <= S_VEC;
                  end
               end
            end
            default: ; // S_ERR swallows bytes until the download falls
         endcase

         // Download gone: leave for IDLE once no request is outstanding
         if (!bus.ioctl_download && state_q != S_IDLE && (!busy_wait || bus.mem_ack)) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            rel_q   <= RC_W'(REL_CYCLES - 1);
         end
      end
   end

   assign bus.ioctl_wait    = wait_q;
   assign bus.cpu_reset     = cpu_reset_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_data      = mem_data_q;
   assign bus.ram_req       = ram_req_q;
   assign bus.rom_req       = rom_req_q;
   assign bus.load_err      = load_err_q;
   assign bus.bytes_written = bw_q;
endmodule

// File: tb/tb_p88_loader.sv
// Bench for p88_loader: directed record table, hand sequences, randomized streams.
// Expected writes come from a record-level parser of the byte stream.
// Memory side acks after a programmable delay and logs every accepted write.
module tb_p88_loader;
   localparam int ADDR_W = 20;
   localparam int LEN_W  = 16;
   localparam int VEC_W  = 3;
   localparam int REL    = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   p88_loader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

   p88_loader #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .VEC_ADDR_W(VEC_W),
      .CMD_DATA(8'hC8), .CMD_VEC(8'hCA), .REL_CYCLES(REL)
   ) dut (
      .clk_sys(clk),
      .resetL(rst_n),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   int          ack_delay = 0;
   int          ack_cnt = 0;
   logic        seen = 1'b0;
   logic [28:0] held;
   logic [28:0] cur;
   logic [28:0] got_q[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         bus.mem_ack = 1'b0;
         seen = 1'b0;
      end else if (bus.mem_ack) begin
         bus.mem_ack = 1'b0;
      end else if (bus.ram_req || bus.rom_req) begin
         cur = {bus.rom_req, bus.mem_addr, bus.mem_data};
         check("req_exclusive", 64'(bus.ram_req & bus.rom_req), 64'd0);
         check("wait_covers_req", 64'(bus.ioctl_wait), 64'd1);
         if (!seen) begin
            seen = 1'b1;
            held = cur;
            ack_cnt = 0;
         end else begin
            check("req_stable", 64'(cur), 64'(held));
         end
         if (ack_cnt >= ack_delay) begin
            bus.mem_ack = 1'b1;
            got_q.push_back(cur);
            seen = 1'b0;
         end else begin
            ack_cnt++;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]  stream_q[$];
   logic [28:0] exp_q[$];
   logic        exp_err;
   int          exp_bw;

   task automatic model_run();
      int i = 0;
      int n = stream_q.size();
      int seg, off, len, a;
      logic [7:0] c;
      exp_q.delete();
      exp_err = 1'b0;
      exp_bw = 0;
      while (i < n && !exp_err) begin
         c = stream_q[i];
         i++;
         if (c == 8'hC8) begin
            if (n - i < 8) exp_err = 1'b1;
            else begin
               seg = stream_q[i] + 256 * stream_q[i+1];
               off = stream_q[i+2] + 256 * stream_q[i+3];
               len = stream_q[i+6] + 256 * stream_q[i+7];
               i += 8;
               a = (seg * 16 + off) % (1 << ADDR_W);
               for (int k = 0; k < len; k++) begin
                  if (i >= n) begin
                     exp_err = 1'b1;
                     break;
                  end
                  exp_q.push_back({1'b0, a[ADDR_W-1:0], stream_q[i]});
                  i++;
                  exp_bw++;
                  a = (a + 1) % (1 << ADDR_W);
               end
            end
         end else if (c == 8'hCA) begin
            if (n - i < 4) exp_err = 1'b1;
            else begin
               exp_q.push_back({1'b1, 20'd0, 8'hEA});
               exp_q.push_back({1'b1, 20'd1, stream_q[i+2]});
               exp_q.push_back({1'b1, 20'd2, stream_q[i+3]});
               exp_q.push_back({1'b1, 20'd3, stream_q[i]});
               exp_q.push_back({1'b1, 20'd4, stream_q[i+1]});
               i += 4;
            end
         end else begin
            exp_err = 1'b1;
         end
      end
   endtask

   // ---------------- drivers ----------------
   logic res_err;
   int   res_bw;

   task automatic wait_idle();
      int t = 0;
      while (bus.ioctl_wait === 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("wait_timeout", 64'(t), 64'd0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.ioctl_dout = b;
      bus.ioctl_wr = 1'b1;
      @(negedge clk);
      bus.ioctl_wr = 1'b0;
      wait_idle();
   endtask

   task automatic send_stream();
      foreach (stream_q[i]) send_byte(stream_q[i]);
   endtask

   task automatic start_download(input string name);
      @(negedge clk);
      bus.ioctl_download = 1'b1;
      @(negedge clk);
      check({name, "_start_cpu_reset"}, 64'(bus.cpu_reset), 64'd1);
      check({name, "_start_err"}, 64'(bus.load_err), 64'd0);
      check({name, "_start_bw"}, 64'(bus.bytes_written), 64'd0);
   endtask

   task automatic end_download(input string name);
      int cnt = 0;
      @(negedge clk);
      bus.ioctl_download = 1'b0;
      do begin
         @(negedge clk);
         cnt++;
      end while (bus.cpu_reset && cnt < 50);
      check({name, "_release_cycles"}, 64'(cnt), 64'(REL + 1));
      res_err = bus.load_err;
      res_bw = int'(bus.bytes_written);
   endtask

   task automatic run_stream(input string name, input int dly);
      ack_delay = dly;
      got_q.delete();
      start_download(name);
      send_stream();
      end_download(name);
   endtask

   task automatic compare_model(input string name);
      int m;
      model_run();
      check({name, "_m_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         check($sformatf("%s_m_wr%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
      check({name, "_m_err"}, 64'(res_err), 64'(exp_err));
      check({name, "_m_bw"}, 64'(res_bw), 64'(exp_bw));
   endtask

   task automatic gen_random();
      int nrec = $urandom_range(1, 3);
      stream_q.delete();
      for (int r = 0; r < nrec; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            stream_q.push_back(8'hCA);
            repeat (4) stream_q.push_back(8'($urandom_range(0, 255)));
         end else begin
            int len = $urandom_range(0, 4);
            stream_q.push_back(8'hC8);
            repeat (6) stream_q.push_back(8'($urandom_range(0, 255)));
            stream_q.push_back(8'(len));
            stream_q.push_back(8'h00);
            repeat (len) stream_q.push_back(8'($urandom_range(0, 255)));
         end
      end
      if ($urandom_range(0, 3) == 0) begin
         int k = $urandom_range(1, 3);
         repeat (k) if (stream_q.size() > 0) void'(stream_q.pop_back());
      end
      if ($urandom_range(0, 5) == 0) begin
         logic [7:0] b = 8'($urandom_range(0, 255));
         if (b == 8'hC8 || b == 8'hCA) b = 8'h55;
         stream_q.push_back(b);
         stream_q.push_back(8'hC8);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct packed {
      logic [159:0] bytes;   // right-justified, first byte most significant
      logic [7:0]   n;
      logic [7:0]   dly;
      logic         err;
      logic [7:0]   bw;
      logic [7:0]   nwr;
      logic [28:0]  first;
      logic [28:0]  last;
   } tv_t;

   tv_t tv[9];

   task automatic load_tv(input int t);
      logic [159:0] bb = tv[t].bytes;
      int n = int'(tv[t].n);
      stream_q.delete();
      for (int i = 0; i < n; i++) stream_q.push_back(bb[8*(n-1-i) +: 8]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{bytes: 160'hC8_0010_0400_0000_0300_AABBCC, n: 8'd12, dly: 8'd0, err: 1'b0,
                bw: 8'd3, nwr: 8'd3, first: {1'b0, 20'h10004, 8'hAA}, last: {1'b0, 20'h10006, 8'hCC}};
      tv[1] = '{bytes: 160'hCA_3412_7856, n: 8'd5, dly: 8'd0, err: 1'b0,
                bw: 8'd0, nwr: 8'd5, first: {1'b1, 20'h0, 8'hEA}, last: {1'b1, 20'h4, 8'h12}};
      tv[2] = '{bytes: 160'hC8_FFFF_0F00_0000_0200_1122, n: 8'd11, dly: 8'd0, err: 1'b0,
                bw: 8'd2, nwr: 8'd2, first: {1'b0, 20'hFFFFF, 8'h11}, last: {1'b0, 20'h00000, 8'h22}};
      tv[3] = '{bytes: 160'hC8_0000_0001_0000_0200_5AA5, n: 8'd11, dly: 8'd5, err: 1'b0,
                bw: 8'd2, nwr: 8'd2, first: {1'b0, 20'h00100, 8'h5A}, last: {1'b0, 20'h00101, 8'hA5}};
      tv[4] = '{bytes: 160'h55_C8_0000, n: 8'd4, dly: 8'd0, err: 1'b1,
                bw: 8'd0, nwr: 8'd0, first: '0, last: '0};
      tv[5] = '{bytes: 160'hC8_0000_2000_0000_0400_0102, n: 8'd11, dly: 8'd0, err: 1'b1,
                bw: 8'd2, nwr: 8'd2, first: {1'b0, 20'h00020, 8'h01}, last: {1'b0, 20'h00021, 8'h02}};
      tv[6] = '{bytes: 160'hC8_0000_0000_0000_0000_C8_0100_0000_0000_0100_77, n: 8'd19, dly: 8'd0,
                err: 1'b0, bw: 8'd1, nwr: 8'd1, first: {1'b0, 20'h00010, 8'h77}, last: {1'b0, 20'h00010, 8'h77}};
      tv[7] = '{bytes: 160'hCA_0100_0200_C8_0000_0000_0000_0100_99, n: 8'd15, dly: 8'd2, err: 1'b0,
                bw: 8'd1, nwr: 8'd6, first: {1'b1, 20'h0, 8'hEA}, last: {1'b0, 20'h00000, 8'h99}};
      tv[8] = '{bytes: 160'hC8_1234, n: 8'd3, dly: 8'd0, err: 1'b1,
                bw: 8'd0, nwr: 8'd0, first: '0, last: '0};

      bus.ioctl_download = 1'b0;
      bus.ioctl_wr = 1'b0;
      bus.ioctl_dout = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cpu_reset", 64'(bus.cpu_reset), 64'd0);
      check("rst_wait", 64'(bus.ioctl_wait), 64'd0);
      check("rst_reqs", 64'({bus.ram_req, bus.rom_req}), 64'd0);
      check("rst_err", 64'(bus.load_err), 64'd0);
      check("rst_bw", 64'(bus.bytes_written), 64'd0);
      check("rst_addr", 64'(bus.mem_addr), 64'd0);
      rst_n = 1'b1;

      // Bytes outside a download are ignored
      got_q.delete();
      send_byte(8'hC8);
      repeat (3) @(negedge clk);
      check("idle_wr_cpu_reset", 64'(bus.cpu_reset), 64'd0);
      check("idle_wr_nwr", 64'(got_q.size()), 64'd0);

      // Directed table
      for (int t = 0; t < 9; t++) begin
         string nm = $sformatf("tv%0d", t);
         load_tv(t);
         run_stream(nm, int'(tv[t].dly));
         check({nm, "_nwr"}, 64'(got_q.size()), 64'(tv[t].nwr));
         if (got_q.size() > 0 && tv[t].nwr > 0) begin
            check({nm, "_first"}, 64'(got_q[0]), 64'(tv[t].first));
            check({nm, "_last"}, 64'(got_q[got_q.size()-1]), 64'(tv[t].last));
         end
         check({nm, "_err"}, 64'(res_err), 64'(tv[t].err));
         check({nm, "_bw"}, 64'(res_bw), 64'(tv[t].bw));
         compare_model(nm);
      end

      // Byte pushed during a stall: dropped and flagged, record otherwise intact
      ack_delay = 5;
      got_q.delete();
      start_download("viol");
      stream_q = '{8'hC8, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      send_stream();
      @(negedge clk); bus.ioctl_dout = 8'h42; bus.ioctl_wr = 1'b1;
      @(negedge clk); bus.ioctl_wr = 1'b0;
      @(negedge clk); bus.ioctl_dout = 8'h43; bus.ioctl_wr = 1'b1;
      @(negedge clk); bus.ioctl_wr = 1'b0;
      wait_idle();
      check("viol_err_live", 64'(bus.load_err), 64'd1);
      end_download("viol");
      check("viol_nwr", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) check("viol_wr", 64'(got_q[0]), 64'({1'b0, 20'h00030, 8'h42}));
      check("viol_bw", 64'(res_bw), 64'd1);

      // Restart during the release countdown
      ack_delay = 0;
      got_q.delete();
      start_download("rst_cd");
      stream_q = '{8'hC8, 8'h00, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h66};
      send_stream();
      @(negedge clk); bus.ioctl_download = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("restart_hold1", 64'(bus.cpu_reset), 64'd1);
      check("restart_bw_before", 64'(bus.bytes_written), 64'd1);
      bus.ioctl_download = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("restart_hold2", 64'(bus.cpu_reset), 64'd1);
      check("restart_bw_cleared", 64'(bus.bytes_written), 64'd0);
      got_q.delete();
      stream_q = '{8'hCA, 8'h78, 8'h56, 8'h34, 8'h12};
      send_stream();
      end_download("restart");
      compare_model("restart");

      // Reset while a DRAM write is stalled
      ack_delay = 1000;
      got_q.delete();
      start_download("arst");
      stream_q = '{8'hC8, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      send_stream();
      @(negedge clk); bus.ioctl_dout = 8'h99; bus.ioctl_wr = 1'b1;
      @(negedge clk); bus.ioctl_wr = 1'b0;
      check("arst_req_before", 64'(bus.ram_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_outputs", 64'({bus.cpu_reset, bus.ram_req, bus.rom_req, bus.ioctl_wait, bus.load_err}), 64'd0);
      check("arst_bw", 64'(bus.bytes_written), 64'd0);
      @(negedge clk);
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      load_tv(0);
      run_stream("after_arst", 0);
      compare_model("after_arst");

      // Randomized streams
      for (int it = 0; it < 40; it++) begin
         string nm = $sformatf("rnd%0d", it);
         gen_random();
         run_stream(nm, $urandom_range(0, 3));
         compare_model(nm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
